prover_compute_v_roundctl: RTL and testbench
============================================

Name: prover_compute_v_roundctl

Overview:
- Downstream of prover_compute_v_encollect: consumes its collected per-lane enable (en_out) and sequences the nRounds compute rounds of one layer across nParallel lanes.
- On start, latches an active-lane mask and issues a launch pulse to all active lanes.
- Waits until every active lane has reported completion, then launches the next round.
- After the last round, pulses done; flags protocol violations.

Parameters:
- nParallel, 16, number of parallel compute lanes (width of en_done/go).
- nRounds, 8, rounds per layer; must be >= 1.
- roundW, $clog2(nRounds) (min 1), width of round counter output.

Ports:
- clk  input  1  clock.
- rstb  input  1  reset; asynchronous, active-high (asserted = 1).
- start  input  1  one-cycle request to begin a layer; honoured only in IDLE.
- lane_en  input  nParallel  active-lane mask; sampled only in the cycle start is accepted.
- en_done  input  nParallel  per-lane completion pulses from prover_compute_v_encollect en_out.
- go  output  nParallel  registered one-cycle launch pulse; equals latched mask during LAUNCH, else 0.
- round  output  roundW  index of current round; 0 in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  registered one-cycle pulse at layer completion.
- err_overrun  output  1  sticky protocol-error flag; cleared by reset or accepted start.

Behaviour:
- Reset (async, rstb=1):
  - state=IDLE; mask, pending, round cleared.
  - go=0, busy=0, done=0, err_overrun=0.
- State IDLE:
  - Accepting start at cycle t latches mask=lane_en, round=0 and clears err_overrun.
  - If lane_en != 0: go to LAUNCH, so go=mask during cycle t+1.
  - If lane_en == 0: go to FINISH (done at t+1, no go issued).
- State LAUNCH (exactly one cycle):
  - go=mask; pending=mask; next state WAIT.
- State WAIT:
  - Each cycle: pending <= pending & ~en_done.
  - Completion is evaluated on the same-cycle value (pending & ~en_done)==0.
  - Completion at cycle t, round < nRounds-1: round++ and go to LAUNCH, so the next go is at t+1.
  - Completion at cycle t, round == nRounds-1: go to FINISH, so done=1 at t+1.
- State FINISH (one cycle):
  - done=1, busy=1; next state IDLE, with round returning to 0.
- Round-to-round throughput: minimum 2 cycles (LAUNCH + one WAIT cycle).
- err_overrun is set (sticky) for any of:
  - en_done bit set for a lane not in mask.
  - en_done bit set for a lane already cleared from pending this round.
  - any en_done bit in IDLE, LAUNCH or FINISH.
  - The offending pulse is otherwise ignored (pending never re-sets).
- start while busy: ignored; no state change; not an error.
- start and en_done in the same IDLE cycle: start accepted; en_done counts as an error after the clear, so err_overrun=1 next cycle.
- round counter wraps nowhere: it never exceeds nRounds-1.
- nRounds=1: a single LAUNCH/WAIT, then FINISH.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no done pulse.
- All outputs are registered or pure decodes of registered state; no combinational path from inputs to outputs.

Test Plan:
- Basic layer:
  - Stimulus: nParallel=16, nRounds=8, lane_en=16'hFFFF, start at cycle 0; each round, all lanes pulse en_done 3 cycles after go.
  - Expected: go=16'hFFFF at cycles 1,5,9,…,29; round steps 0..7; done=1 at cycle 33; busy high from cycles 1–33.
- Staggered lanes:
  - Stimulus: mask 16'h00F0; lanes 4..7 report in separate cycles.
  - Expected: next go only the cycle after lane 7 (the last reporter); go=16'h00F0; err_overrun=0.
- Protocol errors:
  - Stimulus: mask 16'h0003; en_done=16'h0004 in WAIT, then lane 0 pulses twice in one round.
  - Expected: err_overrun=1 from the cycle after the first bad pulse and held; round progression unaffected.
  - Follow-up: a later accepted start clears err_overrun.
- Empty mask and ignored start:
  - Stimulus: start with lane_en=0.
  - Expected: done at cycle 1, go never asserted.
  - Stimulus: start asserted during WAIT.
  - Expected: no effect on round or go.
- Async reset mid-layer:
  - Stimulus: assert rstb in round 3 between clock edges.
  - Expected: go/busy/done/round/err_overrun fall to 0 immediately.
  - Follow-up: after release, start runs a full layer from round 0.
- Randomized soak:
  - Stimulus: random lane_en; random per-lane en_done delays of 1–10 cycles, each lane pulsing once per round.
  - Expected: exactly nRounds go pulses per layer, one done per layer, err_overrun never set.

Source files
------------

// File: rtl/prover_compute_v_roundctl.sv
// Purpose : sequences the nRounds compute rounds of one layer across nParallel
//           lanes, launching each round once every active lane has completed.
// Latency : go one cycle after accepted start (or after last completion); done
//           one cycle after the final round's completion.
// Backpressure: none; start is only honoured in IDLE, protocol misuse of
//           en_done is flagged on err_overrun rather than stalling.
//
// Ports:
//   clk          clock
//   rstb         asynchronous reset, active-high
//   start        one-cycle layer request (honoured only in IDLE)
//   lane_en      active-lane mask, sampled with an accepted start
//   en_done      per-lane completion pulses from the enable collector
//   go           one-cycle launch pulse to the active lanes
//   round        current round index (0 in IDLE)
//   busy         high in every state except IDLE
//   done         one-cycle pulse at layer completion
//   err_overrun  sticky protocol-error flag
module prover_compute_v_roundctl #(
  parameter int nParallel = 16,
  parameter int nRounds   = 8,
  parameter int roundW    = (nRounds > 1) ? $clog2(nRounds) : 1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  input  logic [nParallel-1:0] lane_en,
  input  logic [nParallel-1:0] en_done,
  output logic [nParallel-1:0] go,
  output logic [roundW-1:0]    round,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [roundW-1:0] LAST_ROUND = roundW'(nRounds - 1);

  state_t               state_q;
  logic [nParallel-1:0] mask_q;
  logic [nParallel-1:0] pending_q;
  logic [nParallel-1:0] pending_d;
  logic [nParallel-1:0] go_q;
  logic [roundW-1:0]    round_q;
  logic                 done_q;
  logic                 err_q;
  logic                 err_d;
  logic                 accept;
  logic                 bad_pulse;

  assign accept    = (state_q == S_IDLE) && start;
  assign pending_d = pending_q & ~en_done;

  // While waiting, a pulse is only legal for a lane still pending this round
  // (pending is always a subset of mask). Outside WAIT every pulse is illegal.
  assign bad_pulse = (state_q == S_WAIT) ? |(en_done & ~pending_q) : |en_done;

  // An accepted start clears the flag first, so an illegal pulse in the same
  // cycle still leaves it set.
  assign err_d = (accept ? 1'b0 : err_q) | bad_pulse;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      go_q      <= '0;
      round_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      go_q   <= '0;
      done_q <= 1'b0;
      err_q  <= err_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_q  <= lane_en;
            round_q <= '0;
            if (|lane_en) begin
              state_q <= S_LAUNCH;
              go_q    <= lane_en;
            end else begin
              // Empty layer: nothing to launch, report completion directly.
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          pending_q <= mask_q;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          pending_q <= pending_d;
          // Completion uses this cycle's pulses, saving a cycle per round.
          if (pending_d == '0) begin
            if (round_q == LAST_ROUND) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              round_q <= round_q + roundW'(1);
              state_q <= S_LAUNCH;
              go_q    <= mask_q;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          round_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign go          = go_q;
  assign round       = round_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_prover_compute_v_roundctl.sv
module tb_prover_compute_v_roundctl;

  localparam int NP = 16;
  localparam int NR = 8;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start;
  logic [NP-1:0] lane_en;
  logic [NP-1:0] en_done;
  logic [NP-1:0] go;
  logic [RW-1:0] round;
  logic          busy;
  logic          done;
  logic          err_overrun;

  int errors = 0;
  int checks = 0;

  prover_compute_v_roundctl #(
    .nParallel(NP),
    .nRounds  (NR),
    .roundW   (RW)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .lane_en    (lane_en),
    .en_done    (en_done),
    .go         (go),
    .round      (round),
    .busy       (busy),
    .done       (done),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the LAUNCH cycle of round r0: completes every remaining round
  // with all-lane pulses in the first WAIT cycle, then checks FINISH and IDLE.
  task automatic finish_layer(input logic [NP-1:0] mask, input int r0, input logic exp_err);
    for (int r = r0; r < NR; r++) begin
      tick();
      chk("fl_wait_go", 32'(go), 32'h0);
      en_done = mask;
      tick();
      en_done = '0;
      if (r < NR - 1) begin
        chk("fl_go", 32'(go), 32'(mask));
        chk("fl_round", 32'(round), 32'(r + 1));
      end else begin
        chk("fl_done", 32'(done), 32'h1);
        chk("fl_fin_go", 32'(go), 32'h0);
      end
    end
    chk("fl_err", 32'(err_overrun), 32'(exp_err));
    tick();
    chk("fl_idle_busy", 32'(busy), 32'h0);
    chk("fl_idle_done", 32'(done), 32'h0);
    chk("fl_idle_round", 32'(round), 32'h0);
  endtask

  initial begin
    rstb    = 1'b1;
    start   = 1'b0;
    lane_en = '0;
    en_done = '0;
    #1;
    chk("rst_go", 32'(go), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_round", 32'(round), 32'h0);
    chk("rst_err", 32'(err_overrun), 32'h0);
    tick();
    tick();
    rstb = 1'b0;
    tick();

    // Basic layer: all lanes, completions 3 cycles after each go.
    start   = 1'b1;
    lane_en = 16'hFFFF;
    tick();
    for (int c = 1; c <= 34; c++) begin
      start = 1'b0;
      chk("basic_go", 32'(go), ((c % 4 == 1) && (c <= 29)) ? 32'hFFFF : 32'h0);
      chk("basic_done", 32'(done), (c == 33) ? 32'h1 : 32'h0);
      chk("basic_busy", 32'(busy), (c <= 33) ? 32'h1 : 32'h0);
      chk("basic_round", 32'(round), (c <= 32) ? 32'((c - 1) / 4) : ((c == 33) ? 32'd7 : 32'd0));
      chk("basic_err", 32'(err_overrun), 32'h0);
      en_done = ((c % 4 == 0) && (c <= 32)) ? 16'hFFFF : 16'h0000;
      tick();
    end
    en_done = '0;

    // Staggered lanes 4..7 reporting one per cycle.
    start   = 1'b1;
    lane_en = 16'h00F0;
    tick();
    start = 1'b0;
    chk("stag_go0", 32'(go), 32'h00F0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("stag_nogo", 32'(go), 32'h0);
      en_done = 16'h0010 << k;
      tick();
    end
    en_done = '0;
    chk("stag_go1", 32'(go), 32'h00F0);
    chk("stag_round1", 32'(round), 32'h1);
    chk("stag_err", 32'(err_overrun), 32'h0);
    finish_layer(16'h00F0, 1, 1'b0);

    // Protocol errors: foreign lane, then a double pulse from lane 0.
    start   = 1'b1;
    lane_en = 16'h0003;
    tick();
    start = 1'b0;
    chk("perr_go", 32'(go), 32'h0003);
    tick();
    en_done = 16'h0004;
    tick();
    chk("perr_err_set", 32'(err_overrun), 32'h1);
    chk("perr_round0", 32'(round), 32'h0);
    en_done = 16'h0001;
    tick();
    en_done = 16'h0001;
    tick();
    chk("perr_err_held", 32'(err_overrun), 32'h1);
    chk("perr_still_wait", 32'(go), 32'h0);
    en_done = 16'h0002;
    tick();
    en_done = '0;
    chk("perr_go1", 32'(go), 32'h0003);
    chk("perr_round1", 32'(round), 32'h1);
    finish_layer(16'h0003, 1, 1'b1);

    // New start clears the flag; start during WAIT is ignored.
    start   = 1'b1;
    lane_en = 16'h0003;
    tick();
    start = 1'b0;
    chk("clr_err", 32'(err_overrun), 32'h0);
    chk("clr_go", 32'(go), 32'h0003);
    tick();
    start   = 1'b1;
    lane_en = 16'hFFFF;
    tick();
    start = 1'b0;
    chk("ign_go", 32'(go), 32'h0);
    chk("ign_round", 32'(round), 32'h0);
    chk("ign_busy", 32'(busy), 32'h1);
    en_done = 16'h0003;
    tick();
    en_done = '0;
    chk("ign_go1", 32'(go), 32'h0003);
    chk("ign_round1", 32'(round), 32'h1);
    tick();
    en_done = 16'h0003;
    tick();
    en_done = '0;
    tick();
    en_done = 16'h0007;
    tick();
    en_done = '0;
    chk("ar_pre_go", 32'(go), 32'h0003);
    chk("ar_pre_round", 32'(round), 32'h3);
    chk("ar_pre_err", 32'(err_overrun), 32'h1);

    // Asynchronous reset between edges in round 3.
    #3;
    rstb = 1'b1;
    #1;
    chk("ar_go", 32'(go), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_done", 32'(done), 32'h0);
    chk("ar_round", 32'(round), 32'h0);
    chk("ar_err", 32'(err_overrun), 32'h0);
    @(posedge clk);
    #1;
    rstb = 1'b0;
    tick();
    start   = 1'b1;
    lane_en = 16'hFFFF;
    tick();
    start = 1'b0;
    chk("ar_full_go", 32'(go), 32'hFFFF);
    chk("ar_full_round", 32'(round), 32'h0);
    finish_layer(16'hFFFF, 0, 1'b0);

    // Empty mask: done next cycle, no go.
    start   = 1'b1;
    lane_en = '0;
    tick();
    start = 1'b0;
    chk("empty_done", 32'(done), 32'h1);
    chk("empty_go", 32'(go), 32'h0);
    chk("empty_busy", 32'(busy), 32'h1);
    tick();
    chk("empty_done_end", 32'(done), 32'h0);
    chk("empty_busy_end", 32'(busy), 32'h0);
    chk("empty_go_end", 32'(go), 32'h0);

    // start and en_done in the same IDLE cycle.
    start   = 1'b1;
    lane_en = 16'h0001;
    en_done = 16'h0002;
    tick();
    start   = 1'b0;
    en_done = '0;
    chk("same_err", 32'(err_overrun), 32'h1);
    chk("same_go", 32'(go), 32'h0001);
    finish_layer(16'h0001, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
